chip8_timer_bank: RTL and testbench



---
 rtl/chip8_timer_bank_if.sv | 26 ++
 rtl/chip8_timer_bank.sv | 144 ++++++++++++++
 tb/tb_chip8_timer_bank.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_timer_bank_if.sv
`timescale 1ns/100ps
// chip8_timer_bank_if: CPU-side load/read bus of the CHIP-8 timer bank.
// The master modport is the CPU, the slave modport is the timer bank.
interface chip8_timer_bank_if #(
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = 8
);
  localparam int SEL_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

  logic                  wr_en;
  logic [SEL_W-1:0]      wr_sel;
  logic [WIDTH-1:0]      wr_data;
  logic [SEL_W-1:0]      rd_sel;
  logic [WIDTH-1:0]      rd_data;
  logic [NUM_TIMERS-1:0] active;

  modport master (
    output wr_en, wr_sel, wr_data, rd_sel,
    input  rd_data, active
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_sel,
    output rd_data, active
  );
endinterface

// File: rtl/chip8_timer_bank.sv
`timescale 1ns/100ps
// chip8_timer_bank: two free-running prescalers (CPU step tick, 60 Hz tick)
// and NUM_TIMERS down-counting channels loaded and read by the CPU.
// Channel 0 is the delay timer, channel NUM_TIMERS-1 the sound timer.
// Defining TIMER_BUZZER_EN adds a square-wave buzzer output that runs
// while the sound timer is nonzero.
module chip8_timer_bank #(
  parameter int CLOCK_HZ   = 100000,
  parameter int CPU_HZ     = 500,
  parameter int TIMER_HZ   = 60,
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = 8,
  parameter int BUZZER_HZ  = 440
) (
  input  logic              clk,
  input  logic              rst,
  chip8_timer_bank_if.slave bus,
  output logic              timer_cpu_tick,
  output logic              timer_60hz_tick
`ifdef TIMER_BUZZER_EN
  ,
  output logic              buzzer
`endif
);

  localparam int SEL_W   = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;
  localparam int DIV_CPU = CLOCK_HZ / CPU_HZ;
  localparam int DIV_T   = CLOCK_HZ / TIMER_HZ;
  localparam int CW_CPU  = (DIV_CPU > 0) ? $clog2(DIV_CPU + 1) : 1;
  localparam int CW_T    = (DIV_T > 0) ? $clog2(DIV_T + 1) : 1;

  localparam logic [CW_CPU-1:0] DIV_CPU_C = CW_CPU'(DIV_CPU);
  localparam logic [CW_T-1:0]   DIV_T_C   = CW_T'(DIV_T);

  // Parameter sanity checks, caught at elaboration.
  if (NUM_TIMERS < 1) begin : g_err_num
    $error("chip8_timer_bank: NUM_TIMERS must be >= 1");
  end
  if (CPU_HZ > CLOCK_HZ) begin : g_err_cpu
    $error("chip8_timer_bank: CPU_HZ must not exceed CLOCK_HZ");
  end
  if (TIMER_HZ > CLOCK_HZ) begin : g_err_tmr
    $error("chip8_timer_bank: TIMER_HZ must not exceed CLOCK_HZ");
  end
  if (WIDTH < 1) begin : g_err_width
    $error("chip8_timer_bank: WIDTH must be >= 1");
  end
  if (BUZZER_HZ < 1) begin : g_err_buz
    $error("chip8_timer_bank: BUZZER_HZ must be >= 1");
  end

  logic [CW_CPU-1:0] cpu_cnt;
  logic [CW_T-1:0]   tmr_cnt;
  logic [WIDTH-1:0]  chan [NUM_TIMERS];

  // CPU step prescaler: counts 0..DIV_CPU, so the tick period is DIV_CPU+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_cnt <= '0;
    end else if (cpu_cnt == DIV_CPU_C) begin
      cpu_cnt <= '0;
    end else begin
      cpu_cnt <= cpu_cnt + CW_CPU'(1);
    end
  end

  // 60 Hz prescaler: counts 0..DIV_T, so the tick period is DIV_T+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_cnt <= '0;
    end else if (tmr_cnt == DIV_T_C) begin
      tmr_cnt <= '0;
    end else begin
      tmr_cnt <= tmr_cnt + CW_T'(1);
    end
  end

  // Ticks sit at count 0, so both are high in reset and the first cycle out.
  assign timer_cpu_tick  = (cpu_cnt == '0);
  assign timer_60hz_tick = (tmr_cnt == '0);

  // Channel update: a CPU load wins over the tick; others saturate at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        chan[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (bus.wr_en && (bus.wr_sel == SEL_W'(i))) begin
          chan[i] <= bus.wr_data;
        end else if (timer_60hz_tick && (chan[i] != '0)) begin
          chan[i] <= chan[i] - WIDTH'(1);
        end
      end
    end
  end

  // Zero-latency read mux; a select with no matching channel reads 0.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        bus.rd_data = chan[i];
      end
    end
  end

  // Per-channel nonzero flags.
  always_comb begin
    bus.active = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      bus.active[i] = (chan[i] != '0);
    end
  end

`ifdef TIMER_BUZZER_EN
  localparam int DIV_B = CLOCK_HZ / (2 * BUZZER_HZ);
  localparam int CW_B  = (DIV_B > 0) ? $clog2(DIV_B + 1) : 1;
  localparam logic [CW_B-1:0] DIV_B_C = CW_B'(DIV_B);

  logic [CW_B-1:0] buz_cnt;
  logic            snd_active;

  assign snd_active = (chan[NUM_TIMERS-1] != '0);

  // Buzzer half-period counter; idles at 0 with the output low when silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buz_cnt <= '0;
      buzzer  <= 1'b0;
    end else if (!snd_active) begin
      buz_cnt <= '0;
      buzzer  <= 1'b0;
    end else if (buz_cnt == DIV_B_C) begin
      buz_cnt <= '0;
      buzzer  <= ~buzzer;
    end else begin
      buz_cnt <= buz_cnt + CW_B'(1);
    end
  end
`endif

endmodule

// File: tb/tb_chip8_timer_bank.sv
`timescale 1ns/100ps
// tb_chip8_timer_bank: scoreboard bench for chip8_timer_bank.
// Stimulus pushes (cycle, signal, expected) entries; a monitor pops and
// compares them each cycle. Tick periods are also checked every cycle.
// Buzzer checks are compiled in when TIMER_BUZZER_EN is defined.
module tb_chip8_timer_bank;

  localparam int P_CPU = 201;
  localparam int P_T   = 1667;

  localparam int SIG_RD   = 0;
  localparam int SIG_ACT  = 1;
  localparam int SIG_CPU  = 2;
  localparam int SIG_T    = 3;
  localparam int SIG_RD3  = 4;
  localparam int SIG_ACT3 = 5;
  localparam int SIG_BUZ  = 6;
  localparam int SIG_BUZ3 = 7;

  typedef struct {
    int          n;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  logic cpu_tick, t_tick, cpu_tick3, t_tick3;
`ifdef TIMER_BUZZER_EN
  logic buz, buz3;
`endif

  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb_q[$];
  event sample_now;

  chip8_timer_bank_if #(.NUM_TIMERS(2), .WIDTH(8)) bus ();
  chip8_timer_bank_if #(.NUM_TIMERS(3), .WIDTH(8)) bus3 ();

  chip8_timer_bank dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .timer_cpu_tick  (cpu_tick),
    .timer_60hz_tick (t_tick)
`ifdef TIMER_BUZZER_EN
    ,
    .buzzer          (buz)
`endif
  );

  chip8_timer_bank #(.NUM_TIMERS(3)) dut3 (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus3),
    .timer_cpu_tick  (cpu_tick3),
    .timer_60hz_tick (t_tick3)
`ifdef TIMER_BUZZER_EN
    ,
    .buzzer          (buz3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic string sig_name(input int sig);
    case (sig)
      SIG_RD:   return "rd_data";
      SIG_ACT:  return "active";
      SIG_CPU:  return "cpu_tick";
      SIG_T:    return "60hz_tick";
      SIG_RD3:  return "rd_data3";
      SIG_ACT3: return "active3";
      SIG_BUZ:  return "buzzer";
      default:  return "buzzer3";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      SIG_RD:   return 32'(bus.rd_data);
      SIG_ACT:  return 32'(bus.active);
      SIG_CPU:  return 32'(cpu_tick);
      SIG_T:    return 32'(t_tick);
      SIG_RD3:  return 32'(bus3.rd_data);
      SIG_ACT3: return 32'(bus3.active);
`ifdef TIMER_BUZZER_EN
      SIG_BUZ:  return 32'(buz);
      SIG_BUZ3: return 32'(buz3);
`endif
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
  endtask

  task automatic push_exp(input int n, input int sig, input logic [31:0] exp);
    exp_t e;
    e.n = n;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input int which, input bit wr, input int wsel, input int wdata, input int rsel);
    if (which == 0) begin
      bus.wr_en   = wr;
      bus.wr_sel  = wsel[0:0];
      bus.wr_data = wdata[7:0];
      bus.rd_sel  = rsel[0:0];
    end else begin
      bus3.wr_en   = wr;
      bus3.wr_sel  = wsel[1:0];
      bus3.wr_data = wdata[7:0];
      bus3.rd_sel  = rsel[1:0];
    end
  endtask

  task automatic goto(input int n);
    while (cyc != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: per-cycle tick model plus scoreboard pops for the current cycle.
  always begin
    int cur;
    @(negedge clk or sample_now);
    cur = rst ? -1 : cyc;
    if (!rst) begin
      checkOutput("cpu_tick",   32'(cpu_tick),  32'((cyc % P_CPU) == 0));
      checkOutput("60hz_tick",  32'(t_tick),    32'((cyc % P_T) == 0));
      checkOutput("cpu_tick3",  32'(cpu_tick3), 32'((cyc % P_CPU) == 0));
      checkOutput("60hz_tick3", 32'(t_tick3),   32'((cyc % P_T) == 0));
    end
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q[0];
      if (e.n == cur) begin
        void'(sb_q.pop_front());
        checkOutput(sig_name(e.sig), actual(e.sig), e.exp);
      end else if (cur >= 0 && (e.n == -1 || e.n < cur)) begin
        void'(sb_q.pop_front());
        n_checks++;
        $display("[TB] FAIL %s missed: scheduled cycle %0d, now %0d, expected %0h", sig_name(e.sig), e.n, cur, e.exp);
      end else begin
        break;
      end
    end
  end

  initial begin
    #500000;
    n_checks++;
    $display("[TB] FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    applyStimulus(0, 1'b0, 0, 0, 0);
    applyStimulus(1, 1'b0, 0, 0, 0);

    push_exp(-1, SIG_CPU, 1);
    push_exp(-1, SIG_T, 1);
    push_exp(-1, SIG_RD, 0);
    push_exp(-1, SIG_ACT, 0);
    push_exp(-1, SIG_RD3, 0);
`ifdef TIMER_BUZZER_EN
    push_exp(-1, SIG_BUZ, 0);
`endif
    push_exp(10, SIG_RD, 0);
    push_exp(11, SIG_RD, 3);
    push_exp(11, SIG_ACT, 1);
    push_exp(22, SIG_RD3, 0);
    push_exp(22, SIG_ACT3, 1);
    push_exp(23, SIG_RD3, 7);
    push_exp(25, SIG_RD3, 4);
    push_exp(25, SIG_ACT3, 5);
    push_exp(1667, SIG_RD, 3);
    push_exp(1668, SIG_RD, 2);
    push_exp(3334, SIG_RD, 2);
    push_exp(3335, SIG_RD, 1);
    push_exp(3335, SIG_ACT, 3);
`ifdef TIMER_BUZZER_EN
    push_exp(3335, SIG_BUZ, 0);
`endif
    push_exp(3336, SIG_RD, 5);
`ifdef TIMER_BUZZER_EN
    push_exp(3448, SIG_BUZ, 0);
    push_exp(3449, SIG_BUZ, 1);
    push_exp(3562, SIG_BUZ, 1);
    push_exp(3563, SIG_BUZ, 0);
`endif
    push_exp(5001, SIG_RD, 1);
    push_exp(5001, SIG_ACT, 3);
    push_exp(5002, SIG_RD, 0);
    push_exp(5002, SIG_ACT, 2);
    push_exp(6669, SIG_RD, 0);
    push_exp(6670, SIG_RD, 3);
    push_exp(6701, SIG_ACT, 0);
`ifdef TIMER_BUZZER_EN
    push_exp(6701, SIG_BUZ, 1);
    push_exp(6702, SIG_BUZ, 0);
    push_exp(6800, SIG_BUZ, 0);
`endif
    push_exp(6800, SIG_ACT, 0);
    push_exp(6901, SIG_RD, 9);
    push_exp(6901, SIG_ACT, 1);
    push_exp(6956, SIG_RD, 9);

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    goto(10);   applyStimulus(0, 1'b1, 0, 3, 0);
    goto(11);   applyStimulus(0, 1'b0, 0, 0, 0);
    goto(20);   applyStimulus(1, 1'b1, 0, 7, 0);
    goto(21);   applyStimulus(1, 1'b1, 3, 8'hAA, 0);
    goto(22);   applyStimulus(1, 1'b0, 0, 0, 3);
    goto(23);   applyStimulus(1, 1'b0, 0, 0, 0);
    goto(24);   applyStimulus(1, 1'b1, 2, 4, 0);
    goto(25);   applyStimulus(1, 1'b0, 0, 0, 2);
    goto(26);   applyStimulus(1, 1'b0, 0, 0, 0);
    goto(3334); applyStimulus(0, 1'b1, 1, 5, 0);
    goto(3335); applyStimulus(0, 1'b0, 0, 0, 0);
    goto(3336); applyStimulus(0, 1'b0, 0, 0, 1);
    goto(3337); applyStimulus(0, 1'b0, 0, 0, 0);
    goto(6670); applyStimulus(0, 1'b0, 0, 0, 1);
    goto(6671); applyStimulus(0, 1'b0, 0, 0, 0);
    goto(6700); applyStimulus(0, 1'b1, 1, 0, 0);
    goto(6701); applyStimulus(0, 1'b0, 0, 0, 0);
    goto(6900); applyStimulus(0, 1'b1, 0, 9, 0);
    goto(6901); applyStimulus(0, 1'b0, 0, 0, 0);

    goto(6957);
    push_exp(-1, SIG_RD, 0);
    push_exp(-1, SIG_ACT, 0);
    push_exp(-1, SIG_CPU, 1);
    push_exp(-1, SIG_T, 1);
    push_exp(-1, SIG_RD3, 0);
    push_exp(-1, SIG_ACT3, 0);
`ifdef TIMER_BUZZER_EN
    push_exp(-1, SIG_BUZ3, 0);
`endif
    push_exp(0, SIG_RD, 0);
    push_exp(0, SIG_ACT, 0);
    push_exp(5, SIG_RD, 0);
    #1 rst = 1'b1;
    #0.5 -> sample_now;
    #0.5 rst = 1'b0;

    goto(3400);
    @(negedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      $display("[TB] FAIL %s never checked: scheduled cycle %0d, expected %0h", sig_name(e.sig), e.n, e.exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
